// File: rtl/dither_pkg.sv
// -----------------------------------------------------------------------------
// dither_pkg
// Shared types and constants for the dithering fill engine: FSM state
// encoding, fill modes, Floyd-Steinberg weights (sixteenths) and the
// frame-store byte-lane enable helper.
// -----------------------------------------------------------------------------
package dither_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  localparam logic MODE_THRESH = 1'b0;
  localparam logic MODE_FS     = 1'b1;

  // Error diffusion weights in 1/16 units.
  localparam int FS_W_RIGHT      = 7;
  localparam int FS_W_DOWN_LEFT  = 3;
  localparam int FS_W_DOWN       = 5;
  localparam int FS_W_DOWN_RIGHT = 1;
  localparam int FS_SHIFT        = 4;
  localparam int FS_ROUND        = 8;

  // Active-low byte enable for one byte lane of a 32-bit word.
  function automatic logic [3:0] byte_enable_n(input logic [1:0] lane);
    return ~(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/dither_quant.sv
// -----------------------------------------------------------------------------
// dither_quant
// Combinational quantiser for one colour channel: adds the incoming error,
// clamps to 0..255, rounds to OUT_W bits (saturating at full scale) and
// returns the signed residual error in output-LSB-relative units.
//
// Ports:
//   c     in   8        channel colour value
//   e_in  in   ERR_W    signed error to add before quantising
//   q     out  OUT_W    quantised channel value
//   err   out  ERR_W    signed residual v - (q << S)
// -----------------------------------------------------------------------------
module dither_quant #(
  parameter int OUT_W = 3,
  parameter int ERR_W = (8 - OUT_W) + 6
) (
  input  logic        [7:0]       c,
  input  logic signed [ERR_W-1:0] e_in,
  output logic        [OUT_W-1:0] q,
  output logic signed [ERR_W-1:0] err
);

  localparam int         S    = 8 - OUT_W;
  localparam logic [8:0] HALF = 9'(1 << (S - 1));
  localparam logic [8:0] QMAX = 9'((1 << OUT_W) - 1);

  logic signed [15:0] w_sum;
  logic        [7:0]  w_v;
  logic        [8:0]  w_q_raw;
  logic        [7:0]  w_q_shl;
  logic signed [15:0] w_diff;
  logic               w_diff_unused;

  assign w_sum = $signed({8'd0, c}) + $signed({{(16 - ERR_W){e_in[ERR_W-1]}}, e_in});

  always_comb begin
    w_v = w_sum[7:0];
    if (w_sum < 16'sd0) begin
      w_v = 8'h00;
    end else if (w_sum > 16'sd255) begin
      w_v = 8'hFF;
    end
  end

  // Rounding can carry past full scale (e.g. 255 -> 8 at 3 bits); saturate.
  assign w_q_raw = ({1'b0, w_v} + HALF) >> S;
  assign q       = (w_q_raw > QMAX) ? QMAX[OUT_W-1:0] : w_q_raw[OUT_W-1:0];

  assign w_q_shl = {q, {S{1'b0}}};
  assign w_diff  = $signed({8'd0, w_v}) - $signed({8'd0, w_q_shl});
  assign err     = w_diff[ERR_W-1:0];

  // Residual always fits ERR_W; the upper bits are pure sign extension.
  assign w_diff_unused = ^w_diff[15:ERR_W];

endmodule

// File: rtl/dither_fill_engine.sv
// -----------------------------------------------------------------------------
// dither_fill_engine
// Fills a screen rectangle with one constant colour, quantised per channel to
// OUT_W bits, either by plain rounding or by Floyd-Steinberg error diffusion
// using a per-channel line error buffer. One 8-bit pixel per de_ack.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for req; command latched and validated on req
// CLEAR | zeroing error buffer entries 0..(x_end-x_start), one per cycle
// DRAW  | presenting the current pixel on de_*; advance on de_ack
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req / ack            command request / one-cycle acknowledge
//   busy                 high in CLEAR or DRAW
//   r0..r7               x_start, y_start, x_end, y_end, {ch0,ch1},
//                        {ch2,ch3}, mode (r6[0]), unused
//   de_req / de_ack      pixel write handshake
//   de_addr              word address (byte_addr[19:2])
//   de_nbyte             active-low byte lane enable
//   de_rnw               always write (0)
//   de_w_data            packed pixel replicated to all four lanes
//   de_r_data            unused
// -----------------------------------------------------------------------------
module dither_fill_engine
  import dither_pkg::*;
#(
  parameter int CH       = 3,
  parameter int OUT_W    = 3,
  parameter int MAX_W    = 640,
  parameter int SCREEN_W = 640,
  parameter int ERR_W    = (8 - OUT_W) + 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ack,
  output logic        busy,
  input  logic [15:0] r0,
  input  logic [15:0] r1,
  input  logic [15:0] r2,
  input  logic [15:0] r3,
  input  logic [15:0] r4,
  input  logic [15:0] r5,
  input  logic [15:0] r6,
  input  logic [15:0] r7,
  output logic        de_req,
  input  logic        de_ack,
  output logic [17:0] de_addr,
  output logic [3:0]  de_nbyte,
  output logic        de_rnw,
  output logic [31:0] de_w_data,
  input  logic [31:0] de_r_data
);

  localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int CAT_W = CH * OUT_W;

  state_t r_state, w_state_nxt;

  logic              r_ack;
  logic [15:0]       r_x_start;
  logic [15:0]       r_y_start;
  logic [15:0]       r_y_end;
  logic [31:0]       r_colour;
  logic              r_mode;
  logic [IDX_W-1:0]  r_last_col;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [IDX_W-1:0]  r_col;
  logic [15:0]       r_y;

  // Per channel: error of the pixel to the left, next-row partial for the
  // current column (1*err from x-1), and the pending next-row total for
  // column x-1 that still awaits 3*err from pixel x.
  logic signed [ERR_W-1:0] r_err_left [CH];
  logic signed [ERR_W-1:0] r_acc_cur  [CH];
  logic signed [ERR_W-1:0] r_acc_prev [CH];
  logic signed [ERR_W-1:0] r_nbuf     [CH][MAX_W];

  logic [16:0]             w_span;
  logic                    w_cmd_ok;
  logic                    w_clr_done;
  logic                    w_row_done;
  logic                    w_last_pix;
  logic [31:0]             w_baddr;
  logic [OUT_W-1:0]        w_q      [CH];
  logic signed [ERR_W-1:0] w_err    [CH];
  logic signed [ERR_W-1:0] w_err_dl [CH];
  logic signed [ERR_W-1:0] w_err_d  [CH];
  logic signed [ERR_W-1:0] w_err_dr [CH];
  logic [CAT_W-1:0]        w_cat;
  logic [7:0]              w_pixel;
  logic                    w_unused;

  // Command validation on the live register inputs.
  assign w_span   = {1'b0, r2} - {1'b0, r0};
  assign w_cmd_ok = (r2 >= r0) && (r3 >= r1) &&
                    (w_span < 17'(MAX_W)) && ({1'b0, r2} < 17'(SCREEN_W));

  assign w_clr_done = (r_clr_idx == r_last_col);
  assign w_row_done = (r_col == r_last_col);
  assign w_last_pix = w_row_done && (r_y == r_y_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    de_req      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req && w_cmd_ok) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (w_clr_done) w_state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        busy   = 1'b1;
        de_req = 1'b1;
        if (de_ack && w_last_pix) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_x_start  <= '0;
      r_y_start  <= '0;
      r_y_end    <= '0;
      r_colour   <= '0;
      r_mode     <= MODE_THRESH;
      r_last_col <= '0;
      r_clr_idx  <= '0;
      r_col      <= '0;
      r_y        <= '0;
      for (int c = 0; c < CH; c++) begin
        r_err_left[c] <= '0;
        r_acc_cur[c]  <= '0;
        r_acc_prev[c] <= '0;
      end
    end else begin
      r_ack <= (r_state == ST_IDLE) && req;
      if (r_state == ST_IDLE) begin
        if (req) begin
          r_x_start  <= r0;
          r_y_start  <= r1;
          r_y_end    <= r3;
          r_colour   <= {r4, r5};
          r_mode     <= r6[0];
          r_last_col <= w_span[IDX_W-1:0];
          r_clr_idx  <= '0;
        end
      end else if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (w_clr_done) begin
          r_col <= '0;
          r_y   <= r_y_start;
          for (int c = 0; c < CH; c++) begin
            r_err_left[c] <= '0;
            r_acc_cur[c]  <= '0;
            r_acc_prev[c] <= '0;
          end
        end
      end else if (r_state == ST_DRAW && de_ack) begin
        if (w_row_done) begin
          r_col <= '0;
          r_y   <= r_y + 1'b1;
          for (int c = 0; c < CH; c++) begin
            r_err_left[c] <= '0;
            r_acc_cur[c]  <= '0;
            r_acc_prev[c] <= '0;
          end
        end else begin
          r_col <= r_col + 1'b1;
          for (int c = 0; c < CH; c++) begin
            r_err_left[c] <= w_err[c];
            r_acc_prev[c] <= r_acc_cur[c] + w_err_d[c];
            r_acc_cur[c]  <= w_err_dr[c];
          end
        end
      end
    end
  end

  // Line error buffer. Column x-1 is final once pixel x has contributed its
  // down-left share; at the end of a row the last column is final at once,
  // so up to two entries are written on that ack. Entry x is read for the
  // current pixel before any write to it can happen.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (r_state == ST_CLEAR) begin
        r_nbuf[c][r_clr_idx] <= '0;
      end else if (r_state == ST_DRAW && de_ack) begin
        if (r_col != '0) begin
          r_nbuf[c][r_col - 1'b1] <= r_acc_prev[c] + w_err_dl[c];
        end
        if (w_row_done) begin
          r_nbuf[c][r_col] <= r_acc_cur[c] + w_err_d[c];
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic        [7:0]       w_c;
    logic signed [ERR_W-1:0] w_nrow;
    logic signed [ERR_W+3:0] w_left_x;
    logic signed [ERR_W+3:0] w_nrow_x;
    logic signed [ERR_W+3:0] w_fs_sum;
    logic signed [ERR_W-1:0] w_e_in;
    logic                    w_fs_unused;

    assign w_c    = r_colour[31 - 8*g -: 8];
    assign w_nrow = r_nbuf[g][r_col];

    assign w_left_x = {{4{r_err_left[g][ERR_W-1]}}, r_err_left[g]};
    assign w_nrow_x = {{4{w_nrow[ERR_W-1]}}, w_nrow};
    assign w_fs_sum = w_left_x * (ERR_W+4)'(FS_W_RIGHT) + w_nrow_x + (ERR_W+4)'(FS_ROUND);

    // Taking the bits above FS_SHIFT is the arithmetic shift right.
    assign w_e_in      = (r_mode == MODE_FS) ? w_fs_sum[ERR_W+3:FS_SHIFT] : '0;
    assign w_fs_unused = ^w_fs_sum[FS_SHIFT-1:0];

    dither_quant #(
      .OUT_W (OUT_W),
      .ERR_W (ERR_W)
    ) u_quant (
      .c    (w_c),
      .e_in (w_e_in),
      .q    (w_q[g]),
      .err  (w_err[g])
    );

    assign w_err_dl[g] = w_err[g] * ERR_W'(FS_W_DOWN_LEFT);
    assign w_err_d[g]  = w_err[g] * ERR_W'(FS_W_DOWN);
    assign w_err_dr[g] = w_err[g] * ERR_W'(FS_W_DOWN_RIGHT);

    assign w_cat[(CH-1-g)*OUT_W +: OUT_W] = w_q[g];
  end

  // Channel 0 lands in the MSBs; excess LSBs drop, missing LSBs are zero.
  if (CAT_W >= 8) begin : g_pack_trunc
    assign w_pixel = w_cat[CAT_W-1 -: 8];
  end else begin : g_pack_fill
    assign w_pixel = {w_cat, {(8 - CAT_W){1'b0}}};
  end

  assign w_baddr = 32'(r_x_start) + 32'(r_col) + 32'(r_y) * 32'(SCREEN_W);

  assign ack       = r_ack;
  assign de_addr   = w_baddr[19:2];
  assign de_nbyte  = byte_enable_n(w_baddr[1:0]);
  assign de_rnw    = 1'b0;
  assign de_w_data = {4{w_pixel}};

  assign w_unused = ^{de_r_data, r7, r6[15:1], r_colour, w_cat, w_baddr};

endmodule

// File: tb/tb_dither_fill_engine.sv
module tb_dither_fill_engine;

  localparam int CH       = 3;
  localparam int OUT_W    = 3;
  localparam int MAX_W    = 640;
  localparam int SCREEN_W = 640;
  localparam int S        = 8 - OUT_W;
  localparam int QMAX     = (1 << OUT_W) - 1;
  localparam int CAT_W    = CH * OUT_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ack, busy;
  logic [15:0] r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0, r6 = '0, r7 = '0;
  logic        de_req;
  logic        de_ack = 1'b1;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data = '0;

  dither_fill_engine #(
    .CH(CH), .OUT_W(OUT_W), .MAX_W(MAX_W), .SCREEN_W(SCREEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic [31:0] data;
  } pix_t;

  pix_t       exp_q[$];
  logic [7:0] got_q[$];
  int         model_q0[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         pix_cnt = 0;
  int         ack_cnt = 0;
  int         stall_cycles = 0;
  int         hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each pixel's incoming error is taken straight from its
  // neighbours' residuals (left in this row, three above in the last row).
  task automatic model_cmd(input int xs, input int ys, input int xe, input int ye,
                           input int c0, input int c1, input int c2, input bit fs);
    int prev[CH][SCREEN_W];
    int cur[CH][SCREEN_W];
    int cols[CH];
    int s, e, v, q, cat, pix, ba;
    pix_t p;
    cols = '{c0, c1, c2};
    for (int ch = 0; ch < CH; ch++)
      for (int x = 0; x < SCREEN_W; x++) begin
        prev[ch][x] = 0;
        cur[ch][x]  = 0;
      end
    for (int y = ys; y <= ye; y++) begin
      for (int x = xs; x <= xe; x++) begin
        cat = 0;
        for (int ch = 0; ch < CH; ch++) begin
          e = 0;
          if (fs) begin
            s = (x > xs) ? 7 * cur[ch][x-1] : 0;
            if (y > ys) begin
              s += 5 * prev[ch][x];
              if (x > xs) s += prev[ch][x-1];
              if (x < xe) s += 3 * prev[ch][x+1];
            end
            e = (s + 8) >>> 4;
          end
          v = cols[ch] + e;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          q = (v + (1 << (S - 1))) / (1 << S);
          if (q > QMAX) q = QMAX;
          cur[ch][x] = v - q * (1 << S);
          cat = cat * (1 << OUT_W) + q;
          if (ch == 0) model_q0.push_back(q);
        end
        if (CAT_W > 8) pix = cat >> (CAT_W - 8);
        else           pix = cat << (8 - CAT_W);
        ba = x + y * SCREEN_W;
        p.addr  = 18'(ba >> 2);
        p.nbyte = 4'hF & ~(4'h1 << (ba % 4));
        p.data  = {4{8'(pix)}};
        exp_q.push_back(p);
      end
      for (int ch = 0; ch < CH; ch++)
        for (int x = 0; x < SCREEN_W; x++) prev[ch][x] = cur[ch][x];
    end
  endtask

  // de_ack driver: high unless a stall has been requested.
  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0) begin
      de_ack = 1'b0;
      hold_cnt--;
    end else begin
      de_ack = 1'b1;
    end
  end

  // Compare process: every presented pixel must match the model's next pixel.
  always @(negedge clk) begin
    if (ack) ack_cnt++;
    if (rst_n && de_req) begin
      if (!de_ack) stall_cycles++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", de_addr, de_w_data);
      end else if (de_addr !== exp_q[0].addr || de_nbyte !== exp_q[0].nbyte ||
                   de_w_data !== exp_q[0].data || de_rnw !== 1'b0) begin
        n_errors++;
        $display("FAIL pixel: got addr 0x%0h nbyte %b data 0x%0h rnw %b, expected addr 0x%0h nbyte %b data 0x%0h rnw 0",
                 de_addr, de_nbyte, de_w_data, de_rnw, exp_q[0].addr, exp_q[0].nbyte, exp_q[0].data);
      end
      if (de_ack) begin
        got_q.push_back(de_w_data[7:0]);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        pix_cnt++;
      end
    end
  end

  task automatic issue(input int xs, input int ys, input int xe, input int ye,
                       input logic [15:0] v4, input logic [15:0] v5, input bit mode);
    @(negedge clk);
    r0 = 16'(xs); r1 = 16'(ys); r2 = 16'(xe); r3 = 16'(ye);
    r4 = v4; r5 = v5; r6 = {15'd0, mode};
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("ack_pulse", {31'd0, ack}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_errors++;
      $display("FAIL %s_timeout: still busy=%0d with %0d pixels pending, expected idle", name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_pix(input int target, input int budget, input string name);
    int n = 0;
    while (pix_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d pixels, expected %0d", name, pix_cnt, target);
    end
  endtask

  task automatic check_fs_row(input string name);
    int lit[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    chk({name, "_count"}, got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk({name, "_q0"}, {29'd0, got_q[i][7:5]}, lit[i]);
  endtask

  initial begin
    int base;
    int bad;
    int lit[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    #22;
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_de_req", {31'd0, de_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);

    // Threshold single pixel.
    model_cmd(5, 2, 5, 2, 8'h90, 8'h00, 8'hFF, 1'b0);
    chk("model_thresh_data", exp_q[0].data, 32'hA3A3A3A3);
    issue(5, 2, 5, 2, 16'h9000, 16'hFF00, 1'b0);
    @(negedge clk);
    chk("ack_one_cycle", {31'd0, ack}, 0);
    chk("thr_de_req", {31'd0, de_req}, 1);
    chk("thr_addr", {14'd0, de_addr}, 32'h141);
    chk("thr_nbyte", {28'd0, de_nbyte}, 32'b1101);
    chk("thr_data", de_w_data, 32'hA3A3A3A3);
    wait_idle(50, "thresh");
    repeat (3) @(negedge clk);
    chk("thr_idle_after", {30'd0, busy, de_req}, 0);

    // FS single row, pinned model and DUT.
    model_q0.delete();
    got_q.delete();
    model_cmd(0, 0, 7, 0, 8'h10, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) chk("model_fs_q0", model_q0[i], lit[i]);
    issue(0, 0, 7, 0, 16'h1000, 16'h0000, 1'b1);
    wait_idle(100, "fs_row");
    check_fs_row("fs_row");

    // Same row with a 5-cycle stall after the third pixel.
    got_q.delete();
    stall_cycles = 0;
    model_cmd(0, 0, 7, 0, 8'h10, 8'h00, 8'h00, 1'b1);
    base = pix_cnt;
    issue(0, 0, 7, 0, 16'h1000, 16'h0000, 1'b1);
    wait_pix(base + 3, 100, "stall_start");
    hold_cnt = 5;
    wait_idle(100, "stall_row");
    chk("stall_cycles", stall_cycles, 5);
    check_fs_row("stall_row");

    // Invalid: x_end < x_start, then x_end == SCREEN_W.
    for (int t = 0; t < 2; t++) begin
      if (t == 0) issue(10, 0, 5, 0, 16'h8080, 16'h8000, 1'b0);
      else        issue(600, 0, 640, 0, 16'h8080, 16'h8000, 1'b0);
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy || de_req) bad++;
      end
      chk(t == 0 ? "inv_xend_lt_xstart" : "inv_xend_screen", bad, 0);
    end

    // Reset during DRAW, then a multi-row FS command from scratch.
    model_cmd(0, 0, 9, 3, 8'h37, 8'h80, 8'hEE, 1'b1);
    base = pix_cnt;
    issue(0, 0, 9, 3, 16'h3780, 16'hEE00, 1'b1);
    wait_pix(base + 4, 100, "rst_mid");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_de_req", {31'd0, de_req}, 0);
    chk("rst_mid_ack", {31'd0, ack}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_cmd(3, 1, 6, 3, 8'h10, 8'h55, 8'hC8, 1'b1);
    base = pix_cnt;
    issue(3, 1, 6, 3, 16'h1055, 16'hC800, 1'b1);
    wait_idle(200, "after_rst");
    chk("after_rst_pixels", pix_cnt - base, 12);

    // req held high: one ack per command, next only back in IDLE.
    model_cmd(2, 0, 4, 1, 8'h40, 8'h80, 8'hC0, 1'b0);
    model_cmd(2, 0, 4, 1, 8'h40, 8'h80, 8'hC0, 1'b0);
    base = ack_cnt;
    @(negedge clk);
    r0 = 16'd2; r1 = 16'd0; r2 = 16'd4; r3 = 16'd1;
    r4 = 16'h4080; r5 = 16'hC000; r6 = 16'd0;
    req = 1'b1;
    @(negedge clk);
    bad = 0;
    while (busy && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    chk("held_one_ack", ack_cnt - base, 1);
    bad = 0;
    while (!ack && bad < 10) begin
      @(negedge clk);
      bad++;
    end
    req = 1'b0;
    chk("held_second_ack", {31'd0, ack}, 1);
    wait_idle(100, "held");
    repeat (3) @(negedge clk);
    chk("held_total_acks", ack_cnt - base, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
